decoder_scan_n: RTL

DECODER_SCAN_N -- requirements
Module: decoder_scan_n

---
 rtl/decoder_scan_n_if.sv | 21 ++
 rtl/decoder_scan_n.sv | 80 ++++++++
 2 files changed

// File: rtl/decoder_scan_n_if.sv
// decoder_scan_n_if: control inputs and registered decode outputs of decoder_scan_n
interface decoder_scan_n_if #(parameter int SEL_W = 2) ();
   localparam int OUT_W = 2 ** SEL_W;
   logic             en_in;
   logic             mode_in;
   logic             load_in;
   logic [SEL_W-1:0] sel_in;
   logic [7:0]       dwell_in;
   logic [OUT_W-1:0] y_out;
   logic [SEL_W-1:0] idx_out;
   logic             valid_out;
   logic             wrap_out;
   modport master (
      output en_in, mode_in, load_in, sel_in, dwell_in,
      input  y_out, idx_out, valid_out, wrap_out
   );
   modport slave (
      input  en_in, mode_in, load_in, sel_in, dwell_in,
      output y_out, idx_out, valid_out, wrap_out
   );
endinterface

// File: rtl/decoder_scan_n.sv
// decoder_scan_n: registered one-hot/one-cold decoder with direct-load and auto-scan modes
module decoder_scan_n #(
   parameter int SEL_W      = 2,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input logic            clk_in,
   input logic            rst_in,
   decoder_scan_n_if.slave bus
);
   localparam int OUT_W = 2 ** SEL_W;
   localparam logic [OUT_W-1:0] OFF = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
   typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;
   state_t           state, state_nx;
   logic [OUT_W-1:0] y, y_nx;
   logic [SEL_W-1:0] idx, idx_nx, idx_inc;
   logic             valid, valid_nx, wrap, wrap_nx;
   logic [7:0]       cnt, cnt_nx;
   function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] i);
      return OFF ^ (OUT_W'(1) << i);
   endfunction
   assign idx_inc = idx + 1'b1;
   // next-state and next-output selection; everything holds unless a rule changes it
   always_comb begin
      state_nx = state;
      y_nx     = y;
      idx_nx   = idx;
      valid_nx = valid;
      wrap_nx  = 1'b0;
      cnt_nx   = cnt;
      if (!bus.en_in) begin
         state_nx = IDLE;
         y_nx     = OFF;
         valid_nx = 1'b0;
         cnt_nx   = '0;
      end else if (!bus.mode_in) begin
         state_nx = DIRECT;
         cnt_nx   = '0;
         if (bus.load_in) begin
            y_nx     = decode(bus.sel_in);
            idx_nx   = bus.sel_in;
            valid_nx = 1'b1;
         end
      end else if (state != SCAN) begin
         state_nx = SCAN;
         y_nx     = decode('0);
         idx_nx   = '0;
         valid_nx = 1'b1;
         cnt_nx   = bus.dwell_in;
      end else if (cnt == 8'd0) begin
         idx_nx  = idx_inc;
         y_nx    = decode(idx_inc);
         cnt_nx  = bus.dwell_in;
         wrap_nx = (idx_inc == '0);
      end else begin
         cnt_nx = cnt - 8'd1;
      end
   end
   // state and output registers, cleared asynchronously to the inactive pattern
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state <= IDLE;
         y     <= OFF;
         idx   <= '0;
         valid <= 1'b0;
         wrap  <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         y     <= y_nx;
         idx   <= idx_nx;
         valid <= valid_nx;
         wrap  <= wrap_nx;
         cnt   <= cnt_nx;
      end
   end
   assign bus.y_out     = y;
   assign bus.idx_out   = idx;
   assign bus.valid_out = valid;
   assign bus.wrap_out  = wrap;
endmodule
